// File: rtl/pcie_cc_mem_rd_ctrl_if.sv
// Request handshake and output-FIFO write bus of the completer memory-read
// controller.
//   master : requester / FIFO side (drives REQ, ADDR, LEN, FULL)
//   slave  : controller side (drives ACK, WR_DATA, WR_EN)
interface pcie_cc_mem_rd_ctrl_if #(
  parameter int BRAM_ADDR_WIDTH = 16,
  parameter int LEN_WIDTH       = 11,
  parameter int FIFO_DATA_WIDTH = 128
);
  logic                       CC_MEM_RD_REQ;
  logic                       CC_MEM_RD_ACK;
  logic [BRAM_ADDR_WIDTH-1:0] CC_MEM_RD_ADDR;
  logic [LEN_WIDTH-1:0]       CC_MEM_RD_LEN;
  logic [FIFO_DATA_WIDTH-1:0] CC_RD_MEM_FIFO_WR_DATA;
  logic                       CC_RD_MEM_FIFO_WR_EN;
  logic                       CC_RD_MEM_FIFO_WR_FULL;

  modport master (
    output CC_MEM_RD_REQ, CC_MEM_RD_ADDR, CC_MEM_RD_LEN, CC_RD_MEM_FIFO_WR_FULL,
    input  CC_MEM_RD_ACK, CC_RD_MEM_FIFO_WR_DATA, CC_RD_MEM_FIFO_WR_EN
  );

  modport slave (
    input  CC_MEM_RD_REQ, CC_MEM_RD_ADDR, CC_MEM_RD_LEN, CC_RD_MEM_FIFO_WR_FULL,
    output CC_MEM_RD_ACK, CC_RD_MEM_FIFO_WR_DATA, CC_RD_MEM_FIFO_WR_EN
  );
endinterface

// File: rtl/pcie_cc_mem_rd_ctrl.sv
// Completer memory-read controller: on a 4-phase REQ/ACK request it reads
// CC_MEM_RD_LEN words from BRAM port A starting at CC_MEM_RD_ADDR (word
// aligned, wrapping at the top of the address space) and streams them into
// an output FIFO, flagging the final word in the FIFO word MSB.
// Ports:
//   CLK, RST_N   : clock, asynchronous active-low reset
//   cc (slave)   : request handshake + FIFO write bus
//   RAM_*        : BRAM port A, read-only master, 1-cycle read latency
module pcie_cc_mem_rd_ctrl #(
  parameter int BRAM_DATA_WIDTH = 64,
  parameter int BRAM_ADDR_WIDTH = 16,
  parameter int BRAM_KEEP_WIDTH = 8,
  parameter int LEN_WIDTH       = 11,
  parameter int FIFO_DATA_WIDTH = 128
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  pcie_cc_mem_rd_ctrl_if.slave       cc,
  input  logic [BRAM_DATA_WIDTH-1:0] RAM_DOUT,
  output logic                       RAM_CLK,
  output logic                       RAM_RST,
  output logic                       RAM_EN,
  output logic [BRAM_ADDR_WIDTH-1:0] RAM_ADDR,
  output logic [BRAM_DATA_WIDTH-1:0] RAM_DIN,
  output logic [BRAM_KEEP_WIDTH-1:0] RAM_WE
);

  localparam int unsigned ADDR_SHIFT = (BRAM_DATA_WIDTH == 64) ? 3 : 2;
  localparam logic [BRAM_ADDR_WIDTH-1:0] ADDR_STEP = BRAM_ADDR_WIDTH'(BRAM_DATA_WIDTH / 8);
  localparam logic [BRAM_ADDR_WIDTH-1:0] ADDR_MASK =
    ~((BRAM_ADDR_WIDTH'(1) << ADDR_SHIFT) - BRAM_ADDR_WIDTH'(1));

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    READ  = 4'b0010,
    DRAIN = 4'b0100,
    DONE  = 4'b1000
  } state_t;

  state_t                     state, state_nxt;
  logic [BRAM_ADDR_WIDTH-1:0] addr_cnt;
  logic [LEN_WIDTH-1:0]       rem_cnt;
  logic                       in_flight;
  logic                       in_flight_last;
  logic [BRAM_DATA_WIDTH-1:0] buf_data [2];
  logic                       buf_last [2];
  logic [1:0]                 buf_cnt;
  logic                       rd_ptr, wr_ptr;
  logic                       issue, pop, load;
  logic [2:0]                 occ_after;
  logic [FIFO_DATA_WIDTH-1:0] fifo_word;

  // Occupancy (buffered + in flight) after this cycle's pop; a new read may
  // only issue while this stays below the 2-entry skid buffer depth.
  assign pop       = (buf_cnt != 2'd0) && !cc.CC_RD_MEM_FIFO_WR_FULL;
  assign occ_after = {1'b0, buf_cnt} + {2'b00, in_flight} - {2'b00, pop};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (cc.CC_MEM_RD_REQ) begin
          load      = 1'b1;
          state_nxt = (cc.CC_MEM_RD_LEN != '0) ? READ : DONE;
        end
      end
      READ: begin
        if ((rem_cnt != '0) && (occ_after < 3'd2)) begin
          issue = 1'b1;
          if (rem_cnt == LEN_WIDTH'(1)) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (occ_after == 3'd0) state_nxt = DONE;
      end
      DONE: begin
        if (!cc.CC_MEM_RD_REQ) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      addr_cnt       <= '0;
      rem_cnt        <= '0;
      in_flight      <= 1'b0;
      in_flight_last <= 1'b0;
      buf_cnt        <= '0;
      rd_ptr         <= 1'b0;
      wr_ptr         <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        buf_data[i] <= '0;
        buf_last[i] <= 1'b0;
      end
    end else begin
      if (load) begin
        addr_cnt <= cc.CC_MEM_RD_ADDR & ADDR_MASK;
        rem_cnt  <= cc.CC_MEM_RD_LEN;
      end else if (issue) begin
        addr_cnt <= addr_cnt + ADDR_STEP;
        rem_cnt  <= rem_cnt - LEN_WIDTH'(1);
      end
      // The last-word tag travels alongside the read through the BRAM latency.
      in_flight      <= issue;
      in_flight_last <= issue && (rem_cnt == LEN_WIDTH'(1));
      if (in_flight) begin
        buf_data[wr_ptr] <= RAM_DOUT;
        buf_last[wr_ptr] <= in_flight_last;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      buf_cnt <= occ_after[1:0];
    end
  end

  always_comb begin
    fifo_word = '0;
    if (buf_cnt != 2'd0) begin
      fifo_word[BRAM_DATA_WIDTH-1:0] = buf_data[rd_ptr];
      fifo_word[FIFO_DATA_WIDTH-1]   = buf_last[rd_ptr];
    end
  end

  assign cc.CC_RD_MEM_FIFO_WR_DATA = fifo_word;
  assign cc.CC_RD_MEM_FIFO_WR_EN   = pop;
  assign cc.CC_MEM_RD_ACK          = (state == DONE);

  assign RAM_CLK  = CLK;
  assign RAM_RST  = ~RST_N;
  assign RAM_EN   = issue;
  assign RAM_ADDR = addr_cnt;
  assign RAM_DIN  = '0;
  assign RAM_WE   = '0;

endmodule

// File: tb/tb_pcie_cc_mem_rd_ctrl.sv
// Randomized scoreboard bench for pcie_cc_mem_rd_ctrl. Expected FIFO words
// and BRAM addresses are computed from request address/length arithmetic
// and pushed into queues; an independent monitor pops and compares them.
module tb_pcie_cc_mem_rd_ctrl;
  localparam int DW = 64;
  localparam int AW = 16;
  localparam int KW = 8;
  localparam int LW = 11;
  localparam int FW = 128;
  localparam int NWORDS = 1 << (AW - 3);

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic [DW-1:0] RAM_DOUT = '0;
  logic          RAM_CLK, RAM_RST, RAM_EN;
  logic [AW-1:0] RAM_ADDR;
  logic [DW-1:0] RAM_DIN;
  logic [KW-1:0] RAM_WE;

  pcie_cc_mem_rd_ctrl_if #(.BRAM_ADDR_WIDTH(AW), .LEN_WIDTH(LW), .FIFO_DATA_WIDTH(FW)) cc_if ();

  pcie_cc_mem_rd_ctrl #(
    .BRAM_DATA_WIDTH(DW), .BRAM_ADDR_WIDTH(AW), .BRAM_KEEP_WIDTH(KW),
    .LEN_WIDTH(LW), .FIFO_DATA_WIDTH(FW)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .cc(cc_if),
    .RAM_DOUT(RAM_DOUT), .RAM_CLK(RAM_CLK), .RAM_RST(RAM_RST), .RAM_EN(RAM_EN),
    .RAM_ADDR(RAM_ADDR), .RAM_DIN(RAM_DIN), .RAM_WE(RAM_WE)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // BRAM model: word i holds i, one cycle read latency.
  logic [DW-1:0] mem [NWORDS];
  initial for (int i = 0; i < NWORDS; i++) mem[i] = DW'(i);
  always @(posedge CLK) if (RAM_EN) RAM_DOUT <= mem[RAM_ADDR[AW-1:3]];

  int checks = 0;
  int errors = 0;
  logic [FW-1:0] exp_q[$];
  logic [AW-1:0] addr_q[$];
  int issued = 0;
  int popped = 0;
  int stall_mode = 0;
  int txn_c0 = 0;

  task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_expected(input int addr, input int len);
    logic [FW-1:0] w;
    int idx;
    for (int k = 0; k < len; k++) begin
      idx = ((addr >> 3) + k) % NWORDS;
      w = '0;
      w[DW-1:0] = mem[idx];
      w[FW-1] = (k == len - 1);
      exp_q.push_back(w);
      addr_q.push_back(AW'(idx * 8));
    end
  endtask

  // Monitor: BRAM reads and FIFO writes against the scoreboard queues.
  initial begin
    forever begin
      @(negedge CLK);
      if (RST_N) begin
        if (RAM_EN) begin
          chk("outstanding_lt_2",
              FW'((issued - popped - int'(cc_if.CC_RD_MEM_FIFO_WR_EN)) < 2), FW'(1));
          if (addr_q.size() == 0) chk("unexpected_ram_en", FW'(RAM_EN), '0);
          else                    chk("ram_addr", FW'(RAM_ADDR), FW'(addr_q.pop_front()));
          chk("ram_we_din", FW'({RAM_WE, RAM_DIN}), '0);
          issued++;
        end
        if (cc_if.CC_RD_MEM_FIFO_WR_EN) begin
          if (exp_q.size() == 0) chk("unexpected_wr_en", FW'(cc_if.CC_RD_MEM_FIFO_WR_EN), '0);
          else                   chk("fifo_word", cc_if.CC_RD_MEM_FIFO_WR_DATA, exp_q.pop_front());
          popped++;
        end
      end
    end
  end

  // FIFO full driver: 0 = never, 1 = random, 2 = five cycles from the 2nd write.
  initial begin
    cc_if.CC_RD_MEM_FIFO_WR_FULL = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      case (stall_mode)
        1:       cc_if.CC_RD_MEM_FIFO_WR_FULL = ($urandom_range(0, 2) == 0);
        2:       cc_if.CC_RD_MEM_FIFO_WR_FULL = (cyc >= txn_c0 + 4) && (cyc < txn_c0 + 9);
        default: cc_if.CC_RD_MEM_FIFO_WR_FULL = 1'b0;
      endcase
    end
  end

  task automatic do_txn(input int addr, input int len, input int mode, input bit drop);
    int c0, ack_cyc, hold, exp_lat;
    bit got;
    @(posedge CLK);
    #1;
    cc_if.CC_MEM_RD_ADDR = AW'(addr);
    cc_if.CC_MEM_RD_LEN  = LW'(len);
    cc_if.CC_MEM_RD_REQ  = 1'b1;
    c0 = cyc;
    txn_c0 = c0;
    stall_mode = mode;
    push_expected(addr, len);
    if (drop) begin
      @(posedge CLK);
      #1;
      cc_if.CC_MEM_RD_REQ = 1'b0;
    end
    got = 1'b0;
    ack_cyc = 0;
    for (int n = 0; n < 4000 && !got; n++) begin
      @(negedge CLK);
      if (cc_if.CC_MEM_RD_ACK) begin
        got = 1'b1;
        ack_cyc = cyc;
      end
    end
    stall_mode = 0;
    if (!got) begin
      chk("ack_timeout", FW'(cc_if.CC_MEM_RD_ACK), FW'(1));
      cc_if.CC_MEM_RD_REQ = 1'b0;
      exp_q.delete();
      addr_q.delete();
      repeat (4) @(negedge CLK);
      return;
    end
    chk("words_left_at_ack", FW'(exp_q.size()), '0);
    chk("addrs_left_at_ack", FW'(addr_q.size()), '0);
    if (mode != 1 && !drop) begin
      exp_lat = (len == 0) ? 1 : len + 3 + ((mode == 2) ? 5 : 0);
      chk("ack_latency", FW'(ack_cyc - c0), FW'(exp_lat));
    end
    if (drop) begin
      @(negedge CLK);
      chk("ack_single_cycle", FW'(cc_if.CC_MEM_RD_ACK), '0);
    end else begin
      hold = $urandom_range(0, 2);
      repeat (hold) begin
        @(negedge CLK);
        chk("ack_hold", FW'(cc_if.CC_MEM_RD_ACK), FW'(1));
      end
      @(posedge CLK);
      #1;
      cc_if.CC_MEM_RD_REQ = 1'b0;
      @(negedge CLK);
      chk("ack_before_fall", FW'(cc_if.CC_MEM_RD_ACK), FW'(1));
      @(negedge CLK);
      chk("ack_fall", FW'(cc_if.CC_MEM_RD_ACK), '0);
    end
  endtask

  initial begin
    int p0, a, l, m;
    bit d;
    cc_if.CC_MEM_RD_REQ  = 1'b0;
    cc_if.CC_MEM_RD_ADDR = '0;
    cc_if.CC_MEM_RD_LEN  = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_ack", FW'(cc_if.CC_MEM_RD_ACK), '0);
    chk("rst_wr_en", FW'(cc_if.CC_RD_MEM_FIFO_WR_EN), '0);
    chk("rst_ram_en", FW'(RAM_EN), '0);
    chk("rst_wr_data", cc_if.CC_RD_MEM_FIFO_WR_DATA, '0);
    chk("rst_ram_rst", FW'(RAM_RST), FW'(1));
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    repeat (2) @(posedge CLK);

    do_txn(0, 4, 0, 1'b0);
    do_txn(16, 8, 2, 1'b0);
    do_txn(16'hFFF8, 3, 0, 1'b0);
    do_txn(0, 0, 0, 1'b0);
    do_txn(40, 5, 0, 1'b1);
    do_txn(8, 1, 0, 1'b0);

    // Reset in the middle of a 6-word transfer.
    @(posedge CLK);
    #1;
    cc_if.CC_MEM_RD_ADDR = '0;
    cc_if.CC_MEM_RD_LEN  = LW'(6);
    cc_if.CC_MEM_RD_REQ  = 1'b1;
    push_expected(0, 6);
    p0 = popped;
    for (int n = 0; n < 100 && popped < p0 + 2; n++) begin
      @(negedge CLK);
      #1;
    end
    chk("two_words_before_reset", FW'(popped - p0), FW'(2));
    @(posedge CLK);
    #1;
    RST_N = 1'b0;
    cc_if.CC_MEM_RD_REQ = 1'b0;
    #1;
    chk("async_rst_wr_en", FW'(cc_if.CC_RD_MEM_FIFO_WR_EN), '0);
    chk("async_rst_ram_en", FW'(RAM_EN), '0);
    chk("async_rst_ack", FW'(cc_if.CC_MEM_RD_ACK), '0);
    chk("async_rst_wr_data", cc_if.CC_RD_MEM_FIFO_WR_DATA, '0);
    exp_q.delete();
    addr_q.delete();
    issued = 0;
    popped = 0;
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    repeat (4) @(posedge CLK);
    chk("no_writes_after_reset", FW'(popped), '0);
    do_txn(0, 2, 0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      a = ($urandom_range(0, 3) == 0) ? 65536 - int'($urandom_range(1, 64)) : int'($urandom_range(0, 65535));
      l = $urandom_range(0, 20);
      m = $urandom_range(0, 1);
      d = ($urandom_range(0, 9) == 0);
      do_txn(a, l, m, d);
    end

    repeat (3) @(posedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
